serial_adder: RTL and testbench

- Parametrised bit-serial adder: computes {cout, sum} = a + b + cin over WIDTH clock cycles, one bit per cycle, using a single full-adder cell plus a carry flip-flop.
- Sequential, area-cheap successor to the combinational 1-bit full adder; generalised to WIDTH bits with a start/busy/done handshake.
- Used wherever a multi-bit add is needed and latency is acceptable (lab datapaths, accumulators).

---
 rtl/serial_adder.sv | 95 +++++++++
 tb/tb_serial_adder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop compute {cout, sum} = a + b + cin
// over WIDTH cycles, with a start/busy/done handshake and registered results.
module serial_adder #(
    parameter int WIDTH = 8,
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             carry_next;
    logic             bit_sum;
    logic             accept;
    logic             last_bit;

    assign bit_sum    = a_sh[0] ^ b_sh[0] ^ carry;
    assign carry_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign res_next   = {bit_sum, res_sh[WIDTH-1:1]};
    assign accept     = start && ((state == IDLE) || (state == DONE));
    assign last_bit   = (cnt == CW'(WIDTH - 1));

    // Both handshake outputs decode the state register, so no input reaches them combinationally.
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    next_state = start ? RUN : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Result bits enter at the MSB so the first (LSB) bit ends up at position 0 after WIDTH shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            res_sh <= '0;
            carry  <= cin;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= res_next;
            carry  <= carry_next;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                sum  <= res_next;
                cout <= carry_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: an 8-bit instance for directed cases and a
// 4-bit instance swept over every operand/carry combination.
module tb_serial_adder;

    typedef struct {
        logic [8:0] res;
        int         t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    exp_t exp_q8[$];
    exp_t exp_q4[$];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        else
            passed++;
    endtask

    // Drives a request at a falling edge; the expected result is queued once the rising edge accepts it.
    task automatic applyStimulus(input bit wide, input logic [7:0] a, input logic [7:0] b, input logic c);
        exp_t e;
        if (wide) begin
            a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
            e.res = 9'(a) + 9'(b) + 9'(c);
        end else begin
            a4 = a[3:0]; b4 = b[3:0]; cin4 = c; start4 = 1'b1;
            e.res = 9'(5'(a[3:0]) + 5'(b[3:0]) + 5'(c));
        end
        @(posedge clk);
        #1;
        e.t = cyc;
        if (wide) begin
            exp_q8.push_back(e);
            start8 = 1'b0;
            a8 = ~a8;
            b8 = ~b8;
        end else begin
            exp_q4.push_back(e);
            start4 = 1'b0;
        end
    endtask

    task automatic waitDone(input bit wide, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = wide ? done8 : done4;
        end
        if (!seen) checkOutput(wide ? "timeout8" : "timeout4", 32'd0, 32'd1);
    endtask

    // 8-bit scoreboard: result, latency, pulse width and busy length at every done.
    initial begin
        int   busy_cnt = 0;
        logic prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
                prev_done = 1'b0;
            end else begin
                if (busy8) busy_cnt++;
                if (done8) begin
                    checkOutput("done_pulse8", 32'(prev_done), 32'd0);
                    checkOutput("busy_len8", busy_cnt, 8);
                    busy_cnt = 0;
                    if (exp_q8.size() == 0) begin
                        checkOutput("spurious_done8", 32'(done8), 32'd0);
                    end else begin
                        e = exp_q8.pop_front();
                        checkOutput("result8", 32'({cout8, sum8}), 32'(e.res));
                        checkOutput("latency8", cyc - e.t, 8);
                    end
                end
                prev_done = done8;
            end
        end
    end

    initial begin
        int   busy_cnt = 0;
        logic prev_done = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
                prev_done = 1'b0;
            end else begin
                if (busy4) busy_cnt++;
                if (done4) begin
                    checkOutput("done_pulse4", 32'(prev_done), 32'd0);
                    checkOutput("busy_len4", busy_cnt, 4);
                    busy_cnt = 0;
                    if (exp_q4.size() == 0) begin
                        checkOutput("spurious_done4", 32'(done4), 32'd0);
                    end else begin
                        e = exp_q4.pop_front();
                        checkOutput("result4", 32'({cout4, sum4}), 32'(e.res[4:0]));
                        checkOutput("latency4", cyc - e.t, 4);
                    end
                end
                prev_done = done4;
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy8), 32'd0);
        checkOutput("rst_done", 32'(done8), 32'd0);
        checkOutput("rst_sum", 32'(sum8), 32'd0);
        checkOutput("rst_cout", 32'(cout8), 32'd0);
        #3 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idle_busy", 32'(busy8), 32'd0);
        checkOutput("idle_done", 32'(done8), 32'd0);

        applyStimulus(1, 8'h00, 8'h00, 1'b0);
        waitDone(1, 20);
        applyStimulus(1, 8'hFF, 8'h01, 1'b0);
        waitDone(1, 20);
        applyStimulus(1, 8'hFF, 8'hFF, 1'b1);
        waitDone(1, 20);
        applyStimulus(1, 8'hA5, 8'h5A, 1'b0);
        waitDone(1, 20);

        // A start pulse in the middle of RUN must not be executed or disturb the held result.
        @(negedge clk);
        applyStimulus(1, 8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        checkOutput("hold_sum", 32'(sum8), 32'hFF);
        checkOutput("hold_cout", 32'(cout8), 32'd0);
        waitDone(1, 20);
        repeat (12) @(negedge clk);

        // Back-to-back: the second request is driven during the DONE cycle of the first.
        applyStimulus(1, 8'h03, 8'h04, 1'b1);
        waitDone(1, 20);
        applyStimulus(1, 8'h80, 8'h80, 1'b0);
        checkOutput("b2b_busy", 32'(busy8), 32'd1);
        waitDone(1, 20);

        applyStimulus(1, 8'h12, 8'h34, 1'b0);
        waitDone(1, 20);
        @(negedge clk);
        applyStimulus(1, 8'h55, 8'h11, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy8), 32'd0);
        checkOutput("midrst_sum", 32'(sum8), 32'd0);
        checkOutput("midrst_cout", 32'(cout8), 32'd0);
        exp_q8.delete();
        exp_q4.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("midrst_nodone", 32'(done8), 32'd0);
        applyStimulus(1, 8'h7F, 8'h01, 1'b0);
        waitDone(1, 20);

        for (int i = 0; i < 512; i++) begin
            @(negedge clk);
            applyStimulus(0, 8'(i[3:0]), 8'(i[7:4]), i[8]);
            waitDone(0, 12);
        end

        repeat (20) @(negedge clk);
        checkOutput("drain8", exp_q8.size(), 0);
        checkOutput("drain4", exp_q4.size(), 0);
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
